// File: rtl/rom_arbiter.sv
// Two-requester (fetch/debug) arbiter in front of a single-port combinational ROM.
// One read per cycle: accept at E, ROM address valid E..E+1, data captured at E+1.

module rom_arbiter_rsp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap,
  input  logic [28:0] rom_data,
  output logic        valid,
  output logic [28:0] data
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= cap;
      if (cap) data <= rom_data;
    end
  end
endmodule

module rom_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [10:0] f_addr,
  output logic        f_gnt,
  output logic        f_valid,
  output logic [28:0] f_data,
  input  logic        d_req,
  input  logic [10:0] d_addr,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [28:0] d_data,
  output logic [10:0] AddrROM,
  input  logic [28:0] DataROM
);
  localparam int NUM_REQ = 2;
  localparam int CW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

  logic          pipe_busy;
  logic          owner;      // 0 = fetch, 1 = debug
  logic [CW-1:0] starve_cnt;
  logic          starved, win_f, win_d;

  logic [NUM_REQ-1:0]       cap, vld;
  logic [NUM_REQ-1:0][28:0] rdata;

  // Debug only overrides fetch once it has watched STARVE_MAX fetch grants go by.
  assign starved = d_req && (starve_cnt == CW'(STARVE_MAX));
  assign win_f   = f_req && !starved;
  assign win_d   = d_req && (!f_req || starved);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AddrROM    <= '0;
      owner      <= 1'b0;
      pipe_busy  <= 1'b0;
      f_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      f_gnt     <= win_f;
      d_gnt     <= win_d;
      pipe_busy <= win_f | win_d;
      if (win_f) begin
        AddrROM <= f_addr;
        owner   <= 1'b0;
      end else if (win_d) begin
        AddrROM <= d_addr;
        owner   <= 1'b1;
      end
      if (win_d || !d_req)
        starve_cnt <= '0;
      else if (win_f && starve_cnt != CW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign cap[0] = pipe_busy && !owner;
  assign cap[1] = pipe_busy &&  owner;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    rom_arbiter_rsp u_rsp (
      .clk      (clk),
      .rst_n    (rst_n),
      .cap      (cap[i]),
      .rom_data (DataROM),
      .valid    (vld[i]),
      .data     (rdata[i])
    );
  end

  assign f_valid = vld[0];
  assign d_valid = vld[1];
  assign f_data  = rdata[0];
  assign d_data  = rdata[1];
endmodule
